fpu_multiplier_iter: RTL and testbench

- Parametrised, iterative IEEE-754 binary multiplier; successor of the fixed-FP32 truncating multiplier.
- Accepts packed operand words directly and unpacks/classifies them internally.
- Uses a shift-add datapath (one mantissa bit per cycle), round-to-nearest-even, and underflow handling.
- Provides a valid/ready handshake on both sides. Sits between the FPU operand front-end and the result arbiter.

---
 rtl/fpu_pkg.sv | 41 ++++
 rtl/fpu_operand_unpack.sv | 39 +++
 rtl/fpu_multiplier_iter.sv | 214 +++++++++++++++++++++
 tb/tb_fpu_multiplier_iter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types, FSM states and packed-result helpers.
// Optional build macro: FPU_MUL_INEXACT_EN (adds except_inexact_o).
package fpu_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPECIAL,
    ST_MULT,
    ST_ROUND,
    ST_DONE
  } fpu_state_e;

  localparam int MAX_W = 64;

  // Results are LSB-aligned in a 64-bit word; callers trim to W.
  function automatic logic [MAX_W-1:0] canonical_nan(
    input int exp_w,
    input int frac_w
  );
    return (64'd1 << (exp_w + frac_w)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] signed_inf(
    input logic sign,
    input int   exp_w = 8,
    input int   frac_w = 23
  );
    logic [MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << frac_w;
    r = r | ({63'd0, sign} << (exp_w + frac_w));
    return r;
  endfunction

endpackage

// File: rtl/fpu_operand_unpack.sv
// Splits a packed IEEE word into sign/exp/mantissa and classifies it.
// Subnormals classify as zero (DAZ).
module fpu_operand_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] word_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [FRAC_W:0]       mant_o,
  output fp_class_e             class_o
);

  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_ones;
  logic              frac_zero;

  assign sign_o    = word_i[EXP_W+FRAC_W];
  assign exp_o     = word_i[EXP_W+FRAC_W-1:FRAC_W];
  assign frac      = word_i[FRAC_W-1:0];
  assign exp_zero  = (exp_o == '0);
  assign exp_ones  = (exp_o == '1);
  assign frac_zero = (frac == '0);
  assign mant_o    = {~exp_zero, frac};

  always_comb begin
    class_o = FP_NORMAL;
    unique case (1'b1)
      exp_zero:               class_o = FP_ZERO;
      exp_ones && frac_zero:  class_o = FP_INF;
      exp_ones && !frac_zero: class_o = FP_NAN;
      default:                class_o = FP_NORMAL;
    endcase
  end

endmodule

// File: rtl/fpu_multiplier_iter.sv
// Iterative shift-add IEEE multiplier with RNE rounding and flush-to-zero.
// Optional build macro: FPU_MUL_INEXACT_EN (adds except_inexact_o).
module fpu_multiplier_iter
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [EXP_W+FRAC_W:0]   x_i,
  input  logic [EXP_W+FRAC_W:0]   y_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [EXP_W+FRAC_W:0]   z_o,
  output logic                    except_invalid_operation_o,
  output logic                    except_overflow_o,
`ifdef FPU_MUL_INEXACT_EN
  output logic                    except_inexact_o,
`endif
  output logic                    except_underflow_o
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
  localparam int EW2    = EXP_W + 2;
  localparam int CNT_W  = $clog2(MANT_W);

  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
  localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO_S = '0;
  localparam logic signed [EW2-1:0] EMAX_S = EW2'(2 ** EXP_W - 1);
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(MANT_W - 1);

  logic                sx, sy;
  logic [EXP_W-1:0]    ex, ey;
  logic [MANT_W-1:0]   mx, my;
  fp_class_e           cx, cy;

  fpu_operand_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_x (
    .word_i  (x_i),
    .sign_o  (sx),
    .exp_o   (ex),
    .mant_o  (mx),
    .class_o (cx)
  );

  fpu_operand_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_y (
    .word_i  (y_i),
    .sign_o  (sy),
    .exp_o   (ey),
    .mant_o  (my),
    .class_o (cy)
  );

  fpu_state_e             state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [W-1:0]           z_q;
  logic                   inv_q, ovf_q, unf_q;
  logic                   sign_q;
  logic                   spec_inv_q, spec_inf_q;
  logic [MANT_W-1:0]      ma_q, mb_q;
  logic [2*MANT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q;
  logic signed [EW2-1:0]  e_q;
`ifdef FPU_MUL_INEXACT_EN
  logic                   inx_q;
`endif

  logic any_nan, any_inf, any_zero;
  logic signed [EW2-1:0] esum;

  assign any_nan  = (cx == FP_NAN) || (cy == FP_NAN);
  assign any_inf  = (cx == FP_INF) || (cy == FP_INF);
  assign any_zero = (cx == FP_ZERO) || (cy == FP_ZERO);
  assign esum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_S;

  // One multiplier bit per cycle, LSB first; accumulator shifts right.
  logic [MANT_W:0] psum;
  always_comb begin
    psum  = {1'b0, acc_q[2*MANT_W-1:MANT_W]}
          + (mb_q[0] ? {1'b0, ma_q} : '0);
    acc_d = {psum, acc_q[MANT_W-1:1]};
  end

  logic                  top;
  logic [MANT_W-1:0]     m0;
  logic                  g, s, rnd, carry;
  logic [MANT_W:0]       m1;
  logic signed [EW2-1:0] e1, e2;
  logic [FRAC_W-1:0]     frac_r;
  logic                  r_ovf, r_unf;
  logic                  unused_hidden;

  always_comb begin
    top    = acc_q[2*MANT_W-1];
    m0     = top ? acc_q[2*MANT_W-1:MANT_W] : acc_q[2*MANT_W-2:MANT_W-1];
    g      = top ? acc_q[MANT_W-1] : acc_q[MANT_W-2];
    s      = top ? |acc_q[MANT_W-2:0] : |acc_q[MANT_W-3:0];
    e1     = top ? e_q + ONE_S : e_q;
    rnd    = g & (s | m0[0]);
    m1     = {1'b0, m0} + {{MANT_W{1'b0}}, rnd};
    carry  = m1[MANT_W];
    frac_r = carry ? '0 : m1[FRAC_W-1:0];
    e2     = carry ? e1 + ONE_S : e1;
    r_ovf  = (e2 >= EMAX_S);
    r_unf  = !r_ovf && (e2 <= ZERO_S);
  end

  assign unused_hidden = m1[FRAC_W];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      sign_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_inf_q  <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      e_q         <= '0;
`ifdef FPU_MUL_INEXACT_EN
      inx_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            in_ready_q <= 1'b0;
            sign_q     <= sx ^ sy;
            spec_inv_q <= any_nan || (any_inf && any_zero);
            spec_inf_q <= any_inf;
            ma_q       <= mx;
            mb_q       <= my;
            acc_q      <= '0;
            cnt_q      <= '0;
            e_q        <= esum;
            state_q    <= (any_nan || any_inf || any_zero)
                          ? ST_SPECIAL : ST_MULT;
          end
        end
        ST_SPECIAL: begin
          inv_q <= spec_inv_q;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
`ifdef FPU_MUL_INEXACT_EN
          inx_q <= 1'b0;
`endif
          if (spec_inv_q)
            z_q <= W'(canonical_nan(EXP_W, FRAC_W));
          else if (spec_inf_q)
            z_q <= W'(signed_inf(sign_q, EXP_W, FRAC_W));
          else
            z_q <= {sign_q, {(W-1){1'b0}}};
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_MULT: begin
          acc_q <= acc_d;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          inv_q <= 1'b0;
          ovf_q <= r_ovf;
          unf_q <= r_unf;
`ifdef FPU_MUL_INEXACT_EN
          inx_q <= g | s | r_ovf | r_unf;
`endif
          if (r_ovf)
            z_q <= W'(signed_inf(sign_q, EXP_W, FRAC_W));
          else if (r_unf)
            z_q <= {sign_q, {(W-1){1'b0}}};
          else
            z_q <= {sign_q, e2[EXP_W-1:0], frac_r};
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o                 = in_ready_q;
  assign out_valid_o                = out_valid_q;
  assign z_o                        = z_q;
  assign except_invalid_operation_o = inv_q;
  assign except_overflow_o          = ovf_q;
  assign except_underflow_o         = unf_q;
`ifdef FPU_MUL_INEXACT_EN
  assign except_inexact_o           = inx_q;
`endif

endmodule

// File: tb/tb_fpu_multiplier_iter.sv
// Directed bench for fpu_multiplier_iter (FP32 and binary16 instances).
// Flag vectors are {inexact, invalid, overflow, underflow}.
module tb_fpu_multiplier_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v32, r32, ov32, or32;
  logic [31:0] x32, y32, z32;
  logic        inv32, ovf32, unf32;

  logic        v16, r16, ov16, or16;
  logic [15:0] x16, y16, z16;
  logic        inv16, ovf16, unf16;

`ifdef FPU_MUL_INEXACT_EN
  logic inx32, inx16;
  localparam bit INX = 1'b1;
`else
  localparam bit INX = 1'b0;
`endif

  fpu_multiplier_iter #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clk_i                      (clk),
    .rst_i                      (rst_n),
    .in_valid_i                 (v32),
    .in_ready_o                 (r32),
    .x_i                        (x32),
    .y_i                        (y32),
    .out_valid_o                (ov32),
    .out_ready_i                (or32),
    .z_o                        (z32),
    .except_invalid_operation_o (inv32),
    .except_overflow_o          (ovf32),
`ifdef FPU_MUL_INEXACT_EN
    .except_inexact_o           (inx32),
`endif
    .except_underflow_o         (unf32)
  );

  fpu_multiplier_iter #(.EXP_W(5), .FRAC_W(10)) dut16 (
    .clk_i                      (clk),
    .rst_i                      (rst_n),
    .in_valid_i                 (v16),
    .in_ready_o                 (r16),
    .x_i                        (x16),
    .y_i                        (y16),
    .out_valid_o                (ov16),
    .out_ready_i                (or16),
    .z_o                        (z16),
    .except_invalid_operation_o (inv16),
    .except_overflow_o          (ovf16),
`ifdef FPU_MUL_INEXACT_EN
    .except_inexact_o           (inx16),
`endif
    .except_underflow_o         (unf16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] fl32();
`ifdef FPU_MUL_INEXACT_EN
    return {inx32, inv32, ovf32, unf32};
`else
    return {1'b0, inv32, ovf32, unf32};
`endif
  endfunction

  function automatic logic [3:0] fl16();
`ifdef FPU_MUL_INEXACT_EN
    return {inx16, inv16, ovf16, unf16};
`else
    return {1'b0, inv16, ovf16, unf16};
`endif
  endfunction

  // lat counts edges from the accepting edge (edge 1) to out_valid high.
  task automatic op32(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] z, output logic [3:0] f,
                      output int lat);
    @(negedge clk);
    x32 = a; y32 = b; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    z = z32;
    f = fl32();
    @(negedge clk); or32 = 1'b1;
    @(posedge clk); #1; or32 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] z, output logic [3:0] f,
                      output int lat);
    @(negedge clk);
    x16 = a; y16 = b; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    z = z16;
    f = fl16();
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1; or16 = 1'b0;
  endtask

  logic [31:0] z;
  logic [15:0] h;
  logic [3:0]  f;
  int          lat;
  bit          stable;
  bit          saw;
  logic [31:0] zref;

  initial begin
    rst_n = 1'b0;
    v32 = 0; or32 = 0; x32 = '0; y32 = '0;
    v16 = 0; or16 = 0; x16 = '0; y16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", r32, 1);
    chk("rst_out_valid", ov32, 0);
    chk("rst_z", z32, 0);
    chk("rst_flags", fl32(), 0);
    chk("rst_in_ready16", r16, 1);
    @(negedge clk);
    rst_n = 1'b1;

    op32(32'h3f000000, 32'hbee00000, z, f, lat);
    chk("exact_z", z, 32'hbe600000);
    chk("exact_flags", f, 4'b0000);
    chk("exact_lat", lat, 26);

    op32(32'h3f800001, 32'h3f800001, z, f, lat);
    chk("sticky_z", z, 32'h3f800002);
    chk("sticky_flags", f, {INX, 3'b000});
    chk("sticky_lat", lat, 26);

    op32(32'h3f800001, 32'h3fc00000, z, f, lat);
    chk("tie_z", z, 32'h3fc00002);
    chk("tie_flags", f, {INX, 3'b000});

    op32(32'h7f800000, 32'h00000000, z, f, lat);
    chk("inf0_z", z, 32'h7fffffff);
    chk("inf0_flags", f, 4'b0100);
    chk("inf0_lat", lat, 2);

    op32(32'hc1833333, 32'h80000000, z, f, lat);
    chk("negzero_z", z, 32'h00000000);
    chk("negzero_flags", f, 4'b0000);
    chk("negzero_lat", lat, 2);

    op32(32'hff800000, 32'h4479ff5c, z, f, lat);
    chk("inf_z", z, 32'hff800000);
    chk("inf_flags", f, 4'b0000);
    chk("inf_lat", lat, 2);

    op32(32'h7f7fffff, 32'h40000000, z, f, lat);
    chk("ovf_pos_z", z, 32'h7f800000);
    chk("ovf_pos_flags", f, {INX, 3'b010});

    op32(32'hff7fffff, 32'h40000000, z, f, lat);
    chk("ovf_neg_z", z, 32'hff800000);
    chk("ovf_neg_flags", f, {INX, 3'b010});

    op32(32'h00800000, 32'h00800000, z, f, lat);
    chk("unf_z", z, 32'h00000000);
    chk("unf_flags", f, {INX, 3'b001});

    // Backpressure: 3.0 * 3.0 held for 10 cycles with out_ready low.
    @(negedge clk);
    x32 = 32'h40400000; y32 = 32'h40400000; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 26);
    zref = z32;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (z32 !== zref || r32 !== 1'b0 || ov32 !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_z", z32, 32'h41100000);
    chk("bp_in_ready", r32, 0);
    @(negedge clk); or32 = 1'b1;
    @(posedge clk); #1; or32 = 1'b0;
    chk("bp_release", ov32, 0);

    // Reset during MULT aborts the operation.
    @(negedge clk);
    x32 = 32'h3f800001; y32 = 32'h3fc00000; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_in_ready_busy", r32, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov32, 0);
    chk("mid_rst_ready", r32, 1);
    chk("mid_rst_z", z32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0 || r32 !== 1'b1) saw = 1'b1;
    end
    chk("mid_rst_no_output", saw, 0);

    op32(32'h3f000000, 32'hbee00000, z, f, lat);
    chk("recover_z", z, 32'hbe600000);
    chk("recover_lat", lat, 26);

    op16(16'h3c00, 16'h4000, h, f, lat);
    chk("h_exact_z", h, 16'h4000);
    chk("h_exact_flags", f, 4'b0000);
    chk("h_exact_lat", lat, 13);

    op16(16'h7bff, 16'h4000, h, f, lat);
    chk("h_ovf_z", h, 16'h7c00);
    chk("h_ovf_flags", f, {INX, 3'b010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
